// File: rtl/text_arb_pkg.sv
// Shared types and geometry for the text-buffer write arbiter.
// The optional TEXT_ARB_STATS_EN build adds grant/drop counters.
package text_arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT_CPU = 2'd1,
      GRANT_DBG = 2'd2,
      LOCK_DBG  = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DBG = 1'b1
   } req_id_t;

   localparam int TEXT_COLS      = 80;
   localparam int TEXT_ROWS      = 60;
   localparam int TEXT_CELLS_DEF = TEXT_COLS * TEXT_ROWS;
   localparam int STAT_W         = 16;

endpackage

// File: rtl/text_arb_stats.sv
// Saturating grant/drop counters for the text write arbiter.
// Only instantiated when TEXT_ARB_STATS_EN is defined.
module text_arb_stats
   import text_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_grant,
   input  logic              dbg_grant,
   input  logic              drop,
   output logic [STAT_W-1:0] cpu_grant_count,
   output logic [STAT_W-1:0] dbg_grant_count,
   output logic [STAT_W-1:0] drop_count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_grant_count <= '0;
         dbg_grant_count <= '0;
         drop_count      <= '0;
      end else begin
         if (cpu_grant && cpu_grant_count != '1)
            cpu_grant_count <= cpu_grant_count + 1'b1;
         if (dbg_grant && dbg_grant_count != '1)
            dbg_grant_count <= dbg_grant_count + 1'b1;
         if (drop && drop_count != '1)
            drop_count <= drop_count + 1'b1;
      end
   end

endmodule

// File: rtl/text_write_arbiter.sv
// Round-robin arbiter for the text controller write port with debug lock.
// Define TEXT_ARB_STATS_EN to add saturating grant/drop counters.
module text_write_arbiter
   import text_arb_pkg::*;
#(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 32,
   parameter int TEXT_CELLS   = TEXT_CELLS_DEF,
   parameter int LOCK_TIMEOUT = 64
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_data,
   output logic              cpu_ack,
   input  logic              dbg_req,
   input  logic              dbg_lock,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              dbg_ack,
   output logic              out_write_en,
   output logic [ADDR_W-1:0] out_address,
   output logic [DATA_W-1:0] out_data,
   output logic              range_err
`ifdef TEXT_ARB_STATS_EN
   ,
   output logic [15:0]       cpu_grant_count,
   output logic [15:0]       dbg_grant_count,
   output logic [15:0]       drop_count
`endif
);

   localparam int TMO_W = $clog2(LOCK_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

   arb_state_t        state;
   req_id_t           last_grant;
   logic [TMO_W-1:0]  tmo_cnt;

   logic              take_cpu;
   logic              take_dbg;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              sel_ok;

   // The CPU is ignored while the debug engine holds the lock.
   always_comb begin
      take_cpu = 1'b0;
      take_dbg = 1'b0;
      unique case (state)
         IDLE: begin
            take_cpu = cpu_req &&
                       (!dbg_req || last_grant == REQ_DBG);
            take_dbg = dbg_req && !take_cpu;
         end
         LOCK_DBG: take_dbg = dbg_req;
         default: ;
      endcase
      sel_addr = take_cpu ? cpu_addr : dbg_addr;
      sel_data = take_cpu ? cpu_data : dbg_data;
      sel_ok   = 32'(sel_addr) < TEXT_CELLS;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_grant   <= REQ_DBG;
         tmo_cnt      <= '0;
         cpu_ack      <= 1'b0;
         dbg_ack      <= 1'b0;
         out_write_en <= 1'b0;
         out_address  <= '0;
         out_data     <= '0;
         range_err    <= 1'b0;
      end else begin
         cpu_ack      <= 1'b0;
         dbg_ack      <= 1'b0;
         out_write_en <= 1'b0;
         range_err    <= 1'b0;

         if (take_cpu || take_dbg) begin
            out_address  <= sel_addr;
            out_data     <= sel_data;
            out_write_en <= sel_ok;
            range_err    <= !sel_ok;
            cpu_ack      <= take_cpu;
            dbg_ack      <= take_dbg;
         end

         unique case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (take_cpu)
                  state <= GRANT_CPU;
               else if (take_dbg)
                  state <= GRANT_DBG;
            end
            GRANT_CPU: begin
               tmo_cnt    <= '0;
               last_grant <= REQ_CPU;
               state      <= IDLE;
            end
            GRANT_DBG: begin
               tmo_cnt    <= '0;
               last_grant <= REQ_DBG;
               state      <= dbg_lock ? LOCK_DBG : IDLE;
            end
            LOCK_DBG: begin
               if (take_dbg) begin
                  tmo_cnt <= '0;
                  state   <= GRANT_DBG;
               end else if (!dbg_lock) begin
                  tmo_cnt <= '0;
                  state   <= IDLE;
               end else if (tmo_cnt == TMO_LAST) begin
                  tmo_cnt    <= '0;
                  last_grant <= REQ_DBG;
                  state      <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TEXT_ARB_STATS_EN
   text_arb_stats u_stats (
      .clk             (clk),
      .rst             (rst),
      .cpu_grant       (cpu_ack),
      .dbg_grant       (dbg_ack),
      .drop            (range_err),
      .cpu_grant_count (cpu_grant_count),
      .dbg_grant_count (dbg_grant_count),
      .drop_count      (drop_count)
   );
`endif

endmodule

// File: tb/tb_text_write_arbiter.sv
// Directed bench for text_write_arbiter: grants, round-robin, lock,
// lock timeout, range drops and asynchronous reset.
module tb_text_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [12:0] cpu_addr;
   logic [31:0] cpu_data;
   logic        cpu_ack;
   logic        dbg_req;
   logic        dbg_lock;
   logic [12:0] dbg_addr;
   logic [31:0] dbg_data;
   logic        dbg_ack;
   logic        out_write_en;
   logic [12:0] out_address;
   logic [31:0] out_data;
   logic        range_err;
`ifdef TEXT_ARB_STATS_EN
   logic [15:0] cpu_grant_count;
   logic [15:0] dbg_grant_count;
   logic [15:0] drop_count;
`endif

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   text_write_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_req      (cpu_req),
      .cpu_addr     (cpu_addr),
      .cpu_data     (cpu_data),
      .cpu_ack      (cpu_ack),
      .dbg_req      (dbg_req),
      .dbg_lock     (dbg_lock),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data),
      .dbg_ack      (dbg_ack),
      .out_write_en (out_write_en),
      .out_address  (out_address),
      .out_data     (out_data),
      .range_err    (range_err)
`ifdef TEXT_ARB_STATS_EN
      ,
      .cpu_grant_count (cpu_grant_count),
      .dbg_grant_count (dbg_grant_count),
      .drop_count      (drop_count)
`endif
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Checks a grant cycle: which ack, strobe/drop and the presented cell.
   task automatic chk_grant(input string tag,
                            input logic cack, input logic dack,
                            input logic we, input logic rerr,
                            input logic [12:0] a,
                            input logic [31:0] d);
      chk({tag, "_cack"}, 64'(cpu_ack), 64'(cack));
      chk({tag, "_dack"}, 64'(dbg_ack), 64'(dack));
      chk({tag, "_we"}, 64'(out_write_en), 64'(we));
      chk({tag, "_rerr"}, 64'(range_err), 64'(rerr));
      chk({tag, "_addr"}, 64'(out_address), 64'(a));
      chk({tag, "_data"}, 64'(out_data), 64'(d));
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_q"},
          64'({cpu_ack, dbg_ack, out_write_en, range_err}),
          64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   int stall_hits;

   initial begin
      rst      = 1'b1;
      cpu_req  = 1'b0;
      cpu_addr = '0;
      cpu_data = '0;
      dbg_req  = 1'b0;
      dbg_lock = 1'b0;
      dbg_addr = '0;
      dbg_data = '0;
      repeat (2) @(negedge clk);
      chk_grant("reset", 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Single CPU write
      cpu_req  = 1'b1;
      cpu_addr = 13'h0010;
      cpu_data = 32'h41FF_FFFF;
      @(negedge clk);
      chk_grant("cpu1", 1'b1, 1'b0, 1'b1, 1'b0,
                13'h0010, 32'h41FF_FFFF);
      cpu_req = 1'b0;
      @(negedge clk);
      chk_quiet("cpu1_after");
      chk("cpu1_hold", 64'(out_address), 64'h10);

      // Contention after reset: CPU first, then alternate
      do_reset();
      cpu_addr = 13'd1;
      cpu_data = 32'hC0C0_0001;
      dbg_addr = 13'd2;
      dbg_data = 32'hD0D0_0002;
      cpu_req  = 1'b1;
      dbg_req  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i % 2 == 0)
            chk_grant($sformatf("rr%0d", i), 1'b1, 1'b0,
                      1'b1, 1'b0, 13'd1, 32'hC0C0_0001);
         else
            chk_grant($sformatf("rr%0d", i), 1'b0, 1'b1,
                      1'b1, 1'b0, 13'd2, 32'hD0D0_0002);
         if (i == 3) begin
            cpu_req = 1'b0;
            dbg_req = 1'b0;
         end
         @(negedge clk);
         chk_quiet($sformatf("rr%0d_gap", i));
      end

      // Lock: eight debug writes while the CPU waits
      cpu_addr = 13'h20;
      cpu_data = 32'hC0DE_0020;
      for (int k = 0; k < 8; k++) begin
         dbg_addr = 13'(80 + k);
         dbg_data = 32'hDB00_0000 + 32'(k);
         dbg_lock = (k != 7);
         dbg_req  = 1'b1;
         @(negedge clk);
         chk_grant($sformatf("lock%0d", k), 1'b0, 1'b1, 1'b1,
                   1'b0, 13'(80 + k), 32'hDB00_0000 + 32'(k));
         if (k == 0) cpu_req = 1'b1;
         if (k == 7) dbg_req = 1'b0;
         @(negedge clk);
         chk_quiet($sformatf("lock%0d_gap", k));
      end
      @(negedge clk);
      chk_grant("lock_cpu", 1'b1, 1'b0, 1'b1, 1'b0,
                13'h20, 32'hC0DE_0020);
      cpu_req = 1'b0;
      @(negedge clk);

      // Lock timeout with a CPU request pending
      dbg_addr = 13'd100;
      dbg_data = 32'hDB00_0100;
      dbg_lock = 1'b1;
      dbg_req  = 1'b1;
      @(negedge clk);
      chk_grant("tmo_grant", 1'b0, 1'b1, 1'b1, 1'b0,
                13'd100, 32'hDB00_0100);
      dbg_req  = 1'b0;
      cpu_req  = 1'b1;
      cpu_addr = 13'd200;
      cpu_data = 32'hC0DE_0200;
      stall_hits = 0;
      for (int n = 0; n < 65; n++) begin
         @(negedge clk);
         if (cpu_ack || out_write_en) stall_hits++;
      end
      chk("tmo_stall", 64'(stall_hits), 64'(0));
      @(negedge clk);
      chk_grant("tmo_cpu", 1'b1, 1'b0, 1'b1, 1'b0,
                13'd200, 32'hC0DE_0200);
      cpu_req  = 1'b0;
      dbg_lock = 1'b0;
      @(negedge clk);

      // Range boundaries
      dbg_addr = 13'd4800;
      dbg_data = 32'h5800_0000;
      dbg_req  = 1'b1;
      @(negedge clk);
      chk_grant("rng4800", 1'b0, 1'b1, 1'b0, 1'b1,
                13'd4800, 32'h5800_0000);
      dbg_req = 1'b0;
      @(negedge clk);
      chk_quiet("rng4800_after");
      dbg_addr = 13'd4799;
      dbg_data = 32'h5700_0000;
      dbg_req  = 1'b1;
      @(negedge clk);
      chk_grant("rng4799", 1'b0, 1'b1, 1'b1, 1'b0,
                13'd4799, 32'h5700_0000);
      dbg_req = 1'b0;
      @(negedge clk);
      cpu_addr = 13'h1FFF;
      cpu_data = 32'h5A5A_5A5A;
      cpu_req  = 1'b1;
      @(negedge clk);
      chk_grant("rng_cpu", 1'b1, 1'b0, 1'b0, 1'b1,
                13'h1FFF, 32'h5A5A_5A5A);
      cpu_req = 1'b0;
      @(negedge clk);

      // Reset during a debug grant that follows a CPU grant
      dbg_addr = 13'd7;
      dbg_data = 32'h0000_0777;
      dbg_req  = 1'b1;
      @(negedge clk);
      chk("rst_pre_dack", 64'(dbg_ack), 64'(1));
      #1 rst = 1'b1;
      #1;
      chk_grant("rst_async", 1'b0, 1'b0, 1'b0, 1'b0,
                13'h0, 32'h0);
      dbg_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cpu_addr = 13'd11;
      cpu_data = 32'h1111_1111;
      dbg_addr = 13'd22;
      dbg_data = 32'h2222_2222;
      cpu_req  = 1'b1;
      dbg_req  = 1'b1;
      @(negedge clk);
      chk_grant("rst_first", 1'b1, 1'b0, 1'b1, 1'b0,
                13'd11, 32'h1111_1111);
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      repeat (2) @(negedge clk);
      chk_quiet("end_idle");

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
